// File: rtl/ch_delay_sequencer.sv
// rtl/ch_delay_sequencer.sv - queued issue sequencer for per-channel delay counters
// Optional SEQ_LOOP_EN: stored list is replayed while i_trig stays high.
module ch_delay_sequencer #(
  parameter int NCH     = 4,
  parameter int DW      = 16,
  parameter int DEPTH   = 8,
  parameter int START_W = 2,
  parameter int TO_W    = 20
) (
  input  logic                     o_outreset,
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(NCH)-1:0]   i_wr_ch,
  input  logic [DW-1:0]            i_wr_data,
  input  logic                     i_trig,
  input  logic [NCH-1:0]           i_ch_out,
  output logic [DW-1:0]            o_data,
  output logic [NCH-1:0]           o_ch_en,
  output logic [NCH-1:0]           o_start,
  output logic [NCH-1:0]           o_high_del,
  output logic                     o_busy,
  output logic                     o_seq_done,
  output logic                     o_timeout,
  output logic                     o_wr_err,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int CHW = $clog2(NCH);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int SCW = (START_W > 1) ? $clog2(START_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP} state_t;

  state_t               state_q, state_d;
  logic [2:0]           trig_sync_q;
  logic [NCH-1:0]       ch_s1_q, ch_s2_q, ch_s3_q;
  logic [CHW+DW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [DW-1:0]        data_q, data_d;
  logic [CHW-1:0]       ch_q, ch_d;
  logic [NCH-1:0]       ch_en_q, ch_en_d, start_q, start_d, high_del_q, high_del_d;
  logic                 hd_hold_q, hd_hold_d;
  logic [SCW-1:0]       cnt_q, cnt_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic                 pend_q, pend_d;
  logic                 busy_q, busy_d;
  logic                 seq_done_q, seq_done_d;
  logic                 timeout_q, timeout_d;
  logic                 wr_err_q, wr_err_d;

  logic                 full, push, trig_rise;
  logic [NCH-1:0]       ch_rise;
  logic [CHW-1:0]       head_ch;
  logic [DW-1:0]        head_data;
`ifndef SEQ_LOOP_EN
  logic                 pop;
`endif

  // Sync chains reset high so an input already high at release is not an edge.
  assign trig_rise = trig_sync_q[1] & ~trig_sync_q[2];
  assign ch_rise   = ch_s2_q & ~ch_s3_q;
  assign full      = (level_q == LW'(DEPTH));
  assign {head_ch, head_data} = mem_q[rd_ptr_q];

`ifdef SEQ_LOOP_EN
  assign push = i_wr_en && !full && (i_wr_data != '0) && (state_q == S_IDLE);
`else
  assign push = i_wr_en && !full && (i_wr_data != '0);
`endif

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    ch_d       = ch_q;
    ch_en_d    = ch_en_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    pend_d     = pend_q;
    timeout_d  = timeout_q;
    seq_done_d = 1'b0;
    high_del_d = hd_hold_q ? high_del_q : '0;
    hd_hold_d  = 1'b0;
    wr_err_d   = i_wr_en & ~push;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
`ifndef SEQ_LOOP_EN
    pop        = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (trig_rise && (level_q != '0)) begin
          state_d   = S_LOAD;
          timeout_d = 1'b0;
        end
      end
      S_LOAD: begin
        data_d  = head_data;
        ch_d    = head_ch;
        ch_en_d = NCH'(1) << head_ch;
        cnt_d   = '0;
        to_d    = '0;
        pend_d  = 1'b0;
        state_d = S_START;
`ifdef SEQ_LOOP_EN
        rd_ptr_d = (({1'b0, rd_ptr_q} + 1'b1) == level_q) ? '0 : rd_ptr_q + 1'b1;
`else
        pop      = 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
`endif
      end
      S_START: begin
        // A short channel pulse seen during START is held for WAIT.
        if (ch_rise[ch_q]) pend_d = 1'b1;
        if (cnt_q == SCW'(START_W - 1)) state_d = S_WAIT;
        else cnt_d = cnt_q + 1'b1;
      end
      S_WAIT: begin
        to_d = to_q + 1'b1;
        if (pend_q || ch_rise[ch_q]) begin
          state_d = S_GAP;
          ch_en_d = '0;
        end else if (to_d == '1) begin
          timeout_d  = 1'b1;
          high_del_d = NCH'(1) << ch_q;
          hd_hold_d  = 1'b1;
          state_d    = S_GAP;
          ch_en_d    = '0;
        end
      end
      S_GAP: begin
`ifdef SEQ_LOOP_EN
        if ((rd_ptr_q != '0) || trig_sync_q[1]) state_d = S_LOAD;
`else
        if (level_q != '0) state_d = S_LOAD;
`endif
        else begin
          seq_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_START) ? ch_en_d : '0;
    busy_d  = (state_d != S_IDLE);
`ifdef SEQ_LOOP_EN
    level_d = push ? level_q + 1'b1 : level_q;
`else
    level_d = level_q + LW'(push) - LW'(pop);
`endif
  end

  always_ff @(posedge i_clk or posedge o_outreset) begin
    if (o_outreset) begin
      state_q     <= S_IDLE;
      trig_sync_q <= '1;
      ch_s1_q     <= '1;
      ch_s2_q     <= '1;
      ch_s3_q     <= '1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      data_q      <= '0;
      ch_q        <= '0;
      ch_en_q     <= '0;
      start_q     <= '0;
      high_del_q  <= '0;
      hd_hold_q   <= 1'b0;
      cnt_q       <= '0;
      to_q        <= '0;
      pend_q      <= 1'b0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      timeout_q   <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_sync_q <= {trig_sync_q[1:0], i_trig};
      ch_s1_q     <= i_ch_out;
      ch_s2_q     <= ch_s1_q;
      ch_s3_q     <= ch_s2_q;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      data_q      <= data_d;
      ch_q        <= ch_d;
      ch_en_q     <= ch_en_d;
      start_q     <= start_d;
      high_del_q  <= high_del_d;
      hd_hold_q   <= hd_hold_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      pend_q      <= pend_d;
      busy_q      <= busy_d;
      seq_done_q  <= seq_done_d;
      timeout_q   <= timeout_d;
      wr_err_q    <= wr_err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_wr_ch, i_wr_data};
  end

  assign o_data     = data_q;
  assign o_ch_en    = ch_en_q;
  assign o_start    = start_q;
  assign o_high_del = high_del_q;
  assign o_busy     = busy_q;
  assign o_seq_done = seq_done_q;
  assign o_timeout  = timeout_q;
  assign o_wr_err   = wr_err_q;
  assign o_level    = level_q;

endmodule

// File: tb/tb_ch_delay_sequencer.sv
// tb/tb_ch_delay_sequencer.sv - directed bench for ch_delay_sequencer
module tb_ch_delay_sequencer;
  localparam int NCH = 4, DW = 16, DEPTH = 8, START_W = 3, TO_W = 6;
  localparam int CHW = 2, LW = 4;

  logic            o_outreset, i_clk, i_wr_en, i_trig;
  logic [CHW-1:0]  i_wr_ch;
  logic [DW-1:0]   i_wr_data;
  logic [NCH-1:0]  i_ch_out;
  logic [DW-1:0]   o_data;
  logic [NCH-1:0]  o_ch_en, o_start, o_high_del;
  logic            o_busy, o_seq_done, o_timeout, o_wr_err;
  logic [LW-1:0]   o_level;

  int n_chk = 0;
  int n_fail = 0;

  ch_delay_sequencer #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .START_W(START_W), .TO_W(TO_W)) dut (
    .o_outreset(o_outreset), .i_clk(i_clk), .i_wr_en(i_wr_en), .i_wr_ch(i_wr_ch),
    .i_wr_data(i_wr_data), .i_trig(i_trig), .i_ch_out(i_ch_out), .o_data(o_data),
    .o_ch_en(o_ch_en), .o_start(o_start), .o_high_del(o_high_del), .o_busy(o_busy),
    .o_seq_done(o_seq_done), .o_timeout(o_timeout), .o_wr_err(o_wr_err), .o_level(o_level)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int ch, input int d);
    i_wr_en   = 1'b1;
    i_wr_ch   = CHW'(ch);
    i_wr_data = DW'(d);
    tick;
    i_wr_en   = 1'b0;
  endtask

  task automatic ch_pulse(input int ch);
    i_ch_out = NCH'(1) << ch;
    tick;
    i_ch_out = '0;
  endtask

  task automatic wait_start(input string tag, output int ch);
    int n = 0;
    while (o_start == '0 && n < 300) begin
      tick;
      n++;
    end
    chk(tag, (n < 300), 1);
    ch = -1;
    for (int i = 0; i < NCH; i++) if (o_start[i]) ch = i;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!o_seq_done && n < 300) begin
      tick;
      n++;
    end
    chk(tag, (n < 300), 1);
  endtask

  initial begin
    int c, n;
    o_outreset = 1'b1;
    i_wr_en = 1'b0; i_wr_ch = '0; i_wr_data = '0; i_trig = 1'b0; i_ch_out = '0;
    tick; tick;
    chk("reset_outputs", {o_data, o_ch_en, o_start, o_high_del, o_busy, o_seq_done,
                          o_timeout, o_wr_err, o_level}, 64'h0);
    o_outreset = 1'b0;
    tick;

`ifndef SEQ_LOOP_EN
    // Two entries, responses ~20 cycles after each start
    wr(2, 16'h0010);
    wr(0, 16'h0003);
    chk("t1_level2", o_level, 2);
    i_trig = 1'b1;
    tick; tick; tick;
    chk("t1_no_start_yet", o_start, 4'b0000);
    tick;
    chk("t1_start_latency", o_start, 4'b0100);
    chk("t1_data0", o_data, 16'h0010);
    chk("t1_ch_en0", o_ch_en, 4'b0100);
    chk("t1_level_after_pop", o_level, 1);
    i_trig = 1'b0;
    n = 0;
    while (o_start != '0 && n < 10) begin
      n++;
      tick;
    end
    chk("t1_start_width", n, START_W);
    repeat (17) tick;
    ch_pulse(2);
    wait_start("t1_start1_seen", c);
    chk("t1_second_ch", c, 0);
    chk("t1_data1", o_data, 16'h0003);
    chk("t1_level0", o_level, 0);
    repeat (20) tick;
    ch_pulse(0);
    wait_done("t1_done_seen", n);
    tick;
    chk("t1_done_one_cycle", o_seq_done, 0);
    chk("t1_idle", o_busy, 0);

    // Timeout with no channel response
    wr(2, 7);
    wr(1, 9);
    i_trig = 1'b1;
    wait_start("t3_start_seen", c);
    chk("t3_first_ch", c, 2);
    i_trig = 1'b0;
    n = 0;
    while (o_start != '0 && n < 10) begin
      n++;
      tick;
    end
    n = 0;
    while (o_high_del == '0 && n < 200) begin
      n++;
      tick;
    end
    chk("t3_wait_cycles", n, 63);
    chk("t3_high_del_c1", o_high_del, 4'b0100);
    chk("t3_timeout_set", o_timeout, 1);
    chk("t3_ch_en_dropped", o_ch_en, 4'b0000);
    tick;
    chk("t3_high_del_c2", o_high_del, 4'b0100);
    tick;
    chk("t3_high_del_off", o_high_del, 4'b0000);
    chk("t3_next_start", o_start, 4'b0010);
    chk("t3_next_data", o_data, 16'h0009);
    repeat (5) tick;
    ch_pulse(1);
    wait_done("t3_done_seen", n);
    chk("t3_timeout_sticky", o_timeout, 1);

    // Foreign-channel pulse ignored; short pulse inside START caught
    wr(1, 16'h0020);
    wr(3, 16'h0005);
    i_trig = 1'b1;
    wait_start("t5_start_seen", c);
    chk("t5_first_ch", c, 1);
    chk("t5_timeout_cleared", o_timeout, 0);
    i_trig = 1'b0;
    repeat (4) tick;
    ch_pulse(3);
    repeat (6) tick;
    chk("t5_foreign_ignored_en", o_ch_en, 4'b0010);
    chk("t5_foreign_ignored_busy", o_busy, 1);
    ch_pulse(1);
    wait_start("t5_start2_seen", c);
    chk("t5_second_ch", c, 3);
    ch_pulse(3);
    wait_done("t5_done_seen", n);
    chk("t5_start_window_caught", (n < 10), 1);
    chk("t5_no_timeout", o_timeout, 0);

    // Queue full and zero-code rejection
    for (int i = 0; i < 4; i++) wr(i % 4, i + 1);
    chk("t2_level4", o_level, 4);
    wr(1, 0);
    chk("t2_zero_err", o_wr_err, 1);
    chk("t2_zero_level", o_level, 4);
    tick;
    chk("t2_err_pulse", o_wr_err, 0);
    for (int i = 4; i < 8; i++) wr(i % 4, i + 1);
    chk("t2_level8", o_level, 8);
    chk("t2_no_err", o_wr_err, 0);
    wr(3, 16'h0099);
    chk("t2_full_err", o_wr_err, 1);
    chk("t2_full_level", o_level, 8);

    // Reset in WAIT
    i_trig = 1'b1;
    wait_start("t4_start_seen", c);
    i_trig = 1'b0;
    repeat (5) tick;
    chk("t4_busy_before", o_busy, 1);
    o_outreset = 1'b1;
    #1;
    chk("t4_reset_outputs", {o_data, o_ch_en, o_start, o_high_del, o_busy, o_seq_done,
                             o_timeout, o_wr_err, o_level}, 64'h0);
    tick;
    o_outreset = 1'b0;
    tick; tick;
    i_trig = 1'b1;
    repeat (8) tick;
    chk("t4_empty_trig_busy", o_busy, 0);
    chk("t4_empty_level", o_level, 0);
    i_trig = 1'b0;
`else
    // Loop replay of three entries while trigger held
    wr(0, 4);
    wr(1, 4);
    wr(2, 4);
    i_trig = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_start("t6_start_seen", c);
      chk("t6_order", c, k % 3);
      repeat (3) tick;
      if (k == 4) begin
        wr(3, 5);
        chk("t6_busy_wr_err", o_wr_err, 1);
      end
      ch_pulse(c);
    end
    i_trig = 1'b0;
    wait_start("t6_tail1_seen", c);
    chk("t6_tail1", c, 1);
    repeat (3) tick;
    ch_pulse(c);
    wait_start("t6_tail2_seen", c);
    chk("t6_tail2", c, 2);
    repeat (3) tick;
    ch_pulse(c);
    wait_done("t6_done_seen", n);
    chk("t6_level", o_level, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ch_delay_sequencer.md
Name: ch_delay_sequencer

Overview:
- Initiator side of the per-channel delay counters.
- Host writes a queue of {channel, delay code} entries; on a trigger the block issues them one at a time.
- For each entry it presents the 16-bit delay word, asserts the channel enable and pulses start, then waits for that channel's output pulse before issuing the next entry.
- A stalled channel is aborted via the high-delay (forced reset) line.

Parameters:
- NCH, 4, number of delay channels (power of 2, 2..8).
- DW, 16, delay code width; equals the channel counter data width.
- DEPTH, 8, entry queue depth (power of 2).
- START_W, 2, start pulse width in i_clk cycles (>=1).
- TO_W, 20, timeout counter width; timeout is 2^TO_W-1 cycles.

Ports:
- o_outreset  in  1  asynchronous reset, active-high.
- i_clk  in  1  system clock; all logic on the rising edge.
- i_wr_en  in  1  write strobe, one entry per cycle.
- i_wr_ch  in  log2(NCH)  channel index of the written entry.
- i_wr_data  in  DW  delay code of the written entry.
- i_trig  in  1  sequence trigger; rising edge is detected internally.
- i_ch_out  in  NCH  channel output pulses; asynchronous, 2-flop synchronized.
- o_data  out  DW  delay word to the channel counters.
- o_ch_en  out  NCH  one-hot channel enable.
- o_start  out  NCH  one-hot start pulse.
- o_high_del  out  NCH  one-hot forced channel reset on timeout.
- o_busy  out  1  high outside IDLE.
- o_seq_done  out  1  1-cycle pulse when the queue drains.
- o_timeout  out  1  sticky timeout flag.
- o_wr_err  out  1  1-cycle pulse on a rejected write.
- o_level  out  log2(DEPTH)+1  queue occupancy.

Behaviour:
- Reset values: o_data=0, o_ch_en=0, o_start=0, o_high_del=0, o_busy=0, o_seq_done=0, o_timeout=0, o_wr_err=0, o_level=0. Queue pointers cleared; FSM=IDLE.
- Reset mid-sequence aborts immediately; no output glitch beyond the reset assertion itself.

Queue:
- Circular buffer with DEPTH entries.
- A write is accepted only when the queue is not full and i_wr_data!=0.
- Otherwise the entry is dropped and o_wr_err pulses the next cycle. Code 0 is illegal because the counter would fire at once.
- A write in the same cycle as a pop is allowed; o_level stays unchanged.
- Writes are accepted while busy.

FSM:
- IDLE: on a detected i_trig rising edge with o_level>0 go to LOAD. A trigger with the queue empty is ignored. A trigger while not IDLE is ignored.
- LOAD (1 cycle):
  - Pop the head entry, register o_data and o_ch_en=1<<ch.
  - Clear the timeout counter.
  - o_data and o_ch_en stay stable until the entry completes.
- START (START_W cycles): o_start[ch]=1, then go to WAIT.
- WAIT:
  - On synchronized i_ch_out[ch] rising edge, go to GAP.
  - If the timeout counter reaches all-ones: set o_timeout, assert o_high_del[ch] for 2 cycles, go to GAP.
  - Pulses on other channels are ignored.
- GAP (1 cycle): drop o_ch_en. If o_level>0 go to LOAD; else pulse o_seq_done and go to IDLE.

Timing and edge cases:
- Latency from i_trig rising edge to first o_start: 2 sync cycles + edge detect + LOAD = 4 cycles.
- A channel pulse that occurs during START (pulse shorter than START_W) is still caught: the edge detector runs continuously and its result is latched for WAIT.
- o_timeout is cleared only by reset or by the next accepted trigger.
- Edge detectors are initialised so that an input already high at reset release is not seen as an edge.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- When defined:
  - Entries are not consumed. The read pointer wraps to the first written entry, and o_level counts stored entries.
  - At GAP with the end of the list reached, the FSM returns to LOAD of the first entry while i_trig is still high.
  - If i_trig is low, it pulses o_seq_done and goes to IDLE.
  - Writes while busy are rejected with o_wr_err.
- When undefined: plain consume-on-issue queue as above; loop logic absent.

Test Plan:
1. Reset, write {ch2,0x0010},{ch0,0x0003}, trigger, return each i_ch_out pulse 20 cycles after the matching start -> o_start[2] then o_start[0], o_data=0x0010 then 0x0003, one o_seq_done, o_level=0.
2. Write 9 entries with DEPTH=8 -> 9th rejected with o_wr_err, o_level=8. A write of data 0 -> o_wr_err, level unchanged.
3. Trigger with TO_W=6 and no channel response -> after 63 WAIT cycles: o_high_del[ch] high for 2 cycles, o_timeout=1, sequence continues to the next entry.
4. Assert o_outreset during WAIT -> all outputs 0 immediately, o_level=0. After release, a trigger with the queue empty leaves o_busy=0.
5. i_ch_out pulse on a non-selected channel during WAIT -> ignored. A pulse on the selected channel during the START window -> advances to GAP.
6. (SEQ_LOOP_EN) 3 entries, i_trig held high for 10 issues -> channel order repeats cyclically. After i_trig drops, o_seq_done follows the end of the current pass.
